// File: rtl/match_rate_monitor.sv
// Match-rate monitor: saturating total of detector matches plus a sticky alarm
// raised when THRESH matches land inside a WINDOW-cycle window opened by the first hit.
module match_rate_monitor #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned WINDOW  = 16,
  parameter int unsigned THRESH  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w,
  input  logic               clr,
  output logic [COUNT_W-1:0] total,
  output logic               alarm,
  output logic               busy
);

  localparam int unsigned HITS_W = $clog2(THRESH + 1);
  localparam int unsigned TMR_W  = $clog2(WINDOW);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WINDOW = 2'd1,
    S_ALARM  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [HITS_W-1:0]  hits_q, hits_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [COUNT_W-1:0] total_q, total_d;
  logic               alarm_q, alarm_d;
  logic               busy_q, busy_d;
  logic [HITS_W-1:0]  nh_c;

  assign nh_c = hits_q + HITS_W'(w);

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hits_q  <= '0;
      tmr_q   <= '0;
      total_q <= '0;
      alarm_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hits_q  <= hits_d;
      tmr_q   <= tmr_d;
      total_q <= total_d;
      alarm_q <= alarm_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; the threshold check wins over expiry in the last window cycle.
  always_comb begin
    state_d = state_q;
    hits_d  = hits_q;
    tmr_d   = tmr_q;
    if (clr) begin
      state_d = S_IDLE;
      hits_d  = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w) begin
            state_d = S_WINDOW;
            hits_d  = HITS_W'(1);
            tmr_d   = TMR_W'(WINDOW - 2);
          end
        end
        S_WINDOW: begin
          if (nh_c == HITS_W'(THRESH)) begin
            state_d = S_ALARM;
            hits_d  = nh_c;
          end else if (tmr_q == '0) begin
            state_d = S_IDLE;
            hits_d  = '0;
          end else begin
            hits_d = nh_c;
            tmr_d  = tmr_q - TMR_W'(1);
          end
        end
        S_ALARM: begin
          state_d = S_ALARM;
        end
        default: begin
          state_d = S_IDLE;
          hits_d  = '0;
          tmr_d   = '0;
        end
      endcase
    end
  end

  // Saturating total; a match coinciding with clear is dropped.
  always_comb begin
    total_d = total_q;
    if (clr) begin
      total_d = '0;
    end else if (w && (total_q != {COUNT_W{1'b1}})) begin
      total_d = total_q + COUNT_W'(1);
    end
  end

  assign alarm_d = (state_d == S_ALARM);
  assign busy_d  = (state_d == S_WINDOW);

  assign total = total_q;
  assign alarm = alarm_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_match_rate_monitor.sv
// Directed bench for match_rate_monitor: default instance plus a 4-bit-total
// instance driven by the same stimulus for the saturation case.
module tb_match_rate_monitor;

  logic       clk;
  logic       rst;
  logic       w;
  logic       clr;
  logic [7:0] total;
  logic       alarm;
  logic       busy;
  logic [3:0] total4;
  logic       alarm4;
  logic       busy4;

  int n_checks;
  int n_pass;
  int n_fail;

  logic       obs_busy  [0:63];
  logic       obs_alarm [0:63];
  logic [7:0] obs_total [0:63];

  match_rate_monitor dut (
    .clk(clk), .rst(rst), .w(w), .clr(clr),
    .total(total), .alarm(alarm), .busy(busy)
  );

  match_rate_monitor #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .w(w), .clr(clr),
    .total(total4), .alarm(alarm4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic wv, input logic cv);
    w   = wv;
    clr = cv;
    @(posedge clk);
    #1;
    w   = 1'b0;
    clr = 1'b0;
  endtask

  // Index c holds outputs during cycle c; bit c of pat drives w in cycle c.
  task automatic run_pat(input logic [63:0] pat, input int n);
    logic [63:0] p;
    p = pat;
    obs_busy[0]  = busy;
    obs_alarm[0] = alarm;
    obs_total[0] = total;
    for (int c = 0; c < n; c++) begin
      step(p[c], 1'b0);
      obs_busy[c+1]  = busy;
      obs_alarm[c+1] = alarm;
      obs_total[c+1] = total;
    end
  endtask

  task automatic restart();
    step(1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    rst = 1'b1;
    w   = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_total", 32'(total), 32'd0);
    chk("reset_alarm", 32'(alarm), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Idle: 20 quiet cycles
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      chk("idle_outputs", {30'd0, alarm, busy} | 32'(total), 32'd0);
    end

    // Alarm inside window: hits at 0, 4, 8
    restart();
    run_pat(64'h0000_0000_0000_0111, 41);
    chk("a_busy0", 32'(obs_busy[0]), 32'd0);
    chk("a_busy1", 32'(obs_busy[1]), 32'd1);
    chk("a_busy8", 32'(obs_busy[8]), 32'd1);
    chk("a_alarm8", 32'(obs_alarm[8]), 32'd0);
    chk("a_alarm9", 32'(obs_alarm[9]), 32'd1);
    chk("a_busy9", 32'(obs_busy[9]), 32'd0);
    chk("a_total9", 32'(obs_total[9]), 32'd3);
    chk("a_alarm40", 32'(obs_alarm[40]), 32'd1);
    chk("a_busy40", 32'(obs_busy[40]), 32'd0);

    // Third hit in the last window cycle still counts
    restart();
    run_pat(64'h0000_0000_0000_8021, 17);
    chk("b_alarm15", 32'(obs_alarm[15]), 32'd0);
    chk("b_busy15", 32'(obs_busy[15]), 32'd1);
    chk("b_alarm16", 32'(obs_alarm[16]), 32'd1);
    chk("b_total16", 32'(obs_total[16]), 32'd3);

    // Third hit one cycle late: window expired, new window opens
    restart();
    run_pat(64'h0000_0000_0001_0021, 18);
    chk("c_busy15", 32'(obs_busy[15]), 32'd1);
    chk("c_busy16", 32'(obs_busy[16]), 32'd0);
    chk("c_alarm16", 32'(obs_alarm[16]), 32'd0);
    chk("c_busy17", 32'(obs_busy[17]), 32'd1);
    chk("c_alarm17", 32'(obs_alarm[17]), 32'd0);
    chk("c_total17", 32'(obs_total[17]), 32'd3);

    // Hit in the expiry cycle below threshold: counted only, no new window
    restart();
    run_pat(64'h0000_0000_0000_8001, 18);
    chk("e_busy16", 32'(obs_busy[16]), 32'd0);
    chk("e_busy17", 32'(obs_busy[17]), 32'd0);
    chk("e_total16", 32'(obs_total[16]), 32'd2);
    chk("e_alarm17", 32'(obs_alarm[17]), 32'd0);

    // Consecutive hits 0-2
    restart();
    run_pat(64'h0000_0000_0000_0007, 4);
    chk("d_alarm2", 32'(obs_alarm[2]), 32'd0);
    chk("d_alarm3", 32'(obs_alarm[3]), 32'd1);
    chk("d_total3", 32'(obs_total[3]), 32'd3);
    chk("d_busy3", 32'(obs_busy[3]), 32'd0);

    // Clear beats a simultaneous match while in alarm
    step(1'b1, 1'b1);
    chk("clr_total", 32'(total), 32'd0);
    chk("clr_alarm", 32'(alarm), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0);
    chk("clr_nowin_busy", 32'(busy), 32'd0);
    chk("clr_nowin_total", 32'(total), 32'd0);

    // Asynchronous reset mid-window
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("ar_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_win_busy", 32'(busy), 32'd0);
    chk("ar_win_total", 32'(total), 32'd0);
    #1 rst = 1'b0;

    // Asynchronous reset mid-alarm
    run_pat(64'h0000_0000_0000_0007, 5);
    chk("ar_pre_alarm", 32'(alarm), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_alm_alarm", 32'(alarm), 32'd0);
    chk("ar_alm_total", 32'(total), 32'd0);
    chk("ar_alm_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;

    // Saturation on the 4-bit instance: 20 pulses, 3 cycles apart
    restart();
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0);
      chk("sat_total4", 32'(total4), (k > 15) ? 32'd15 : 32'(k));
      if (k == 2) chk("sat_alarm_k2", 32'(alarm4), 32'd0);
      if (k == 3) chk("sat_alarm_k3", 32'(alarm4), 32'd1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("sat_final4", 32'(total4), 32'd15);
    chk("sat_total8", 32'(total), 32'd20);
    chk("sat_alarm_end", 32'(alarm4), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
